// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file write-back path.
// Write-port bundle, write-back source encoding, register counts.
package rf_pkg;
  localparam int A_WIDTH = 5;
  localparam int D_WIDTH = 32;
  localparam int NREG    = 32;

  typedef enum logic {
    WB_SRC_ALU,
    WB_SRC_LSU
  } wb_src_e;

  typedef struct packed {
    logic               we;
    logic [A_WIDTH-1:0] waddr;
    logic [D_WIDTH-1:0] wd;
  } wb_port_t;
endpackage

// File: rtl/rf_rr_arb2.sv
// Two-request round-robin arbiter with a last-grant flop.
// Ports: clk, rst, req_alu/req_lsu in; rdy_*, gnt_* out.
module rf_rr_arb2
  import rf_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_alu,
  input  logic req_lsu,
  output logic rdy_alu,
  output logic rdy_lsu,
  output logic gnt_alu,
  output logic gnt_lsu
);

  wb_src_e last;

  assign rdy_alu = !req_lsu || (last == WB_SRC_LSU);
  assign rdy_lsu = !req_alu || (last == WB_SRC_ALU);
  assign gnt_alu = req_alu && rdy_alu;
  assign gnt_lsu = req_lsu && rdy_lsu;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= WB_SRC_LSU;
    end else begin
      unique case (1'b1)
        gnt_alu: last <= WB_SRC_ALU;
        gnt_lsu: last <= WB_SRC_LSU;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter, registered RF write port, pending-write map.
// Ports: alu_*/lsu_* requests, issue_*, rf_* write port, busy.
// Option: RF_WB_SCOREBOARD_EN builds the busy scoreboard.
module rf_wb_arbiter
  import rf_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_vld,
  output logic               alu_rdy,
  input  logic [A_WIDTH-1:0] alu_rd,
  input  logic [D_WIDTH-1:0] alu_wd,
  input  logic               lsu_vld,
  output logic               lsu_rdy,
  input  logic [A_WIDTH-1:0] lsu_rd,
  input  logic [D_WIDTH-1:0] lsu_wd,
  input  logic               issue_vld,
  input  logic [A_WIDTH-1:0] issue_rd,
  output logic               rf_we,
  output logic [A_WIDTH-1:0] rf_waddr,
  output logic [D_WIDTH-1:0] rf_wd,
  output logic [NREG-1:0]    busy
);

  logic               gnt_alu;
  logic               gnt_lsu;
  logic               acc;
  logic [A_WIDTH-1:0] sel_rd;
  logic [D_WIDTH-1:0] sel_wd;
  logic               do_wr;
  wb_port_t           wp_q;

  rf_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_alu (alu_vld),
    .req_lsu (lsu_vld),
    .rdy_alu (alu_rdy),
    .rdy_lsu (lsu_rdy),
    .gnt_alu (gnt_alu),
    .gnt_lsu (gnt_lsu)
  );

  assign acc = gnt_alu || gnt_lsu;

  always_comb begin
    sel_rd = alu_rd;
    sel_wd = alu_wd;
    if (gnt_lsu) begin
      sel_rd = lsu_rd;
      sel_wd = lsu_wd;
    end
  end

  // x0 writes complete the handshake but never reach the RF.
  assign do_wr = acc && (sel_rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
    end else begin
      wp_q.we <= do_wr;
      if (do_wr) begin
        wp_q.waddr <= sel_rd;
        wp_q.wd    <= sel_wd;
      end
    end
  end

  assign rf_we    = wp_q.we;
  assign rf_waddr = wp_q.waddr;
  assign rf_wd    = wp_q.wd;

`ifdef RF_WB_SCOREBOARD_EN
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] set_m;
  logic [NREG-1:0] clr_m;

  always_comb begin
    set_m = '0;
    clr_m = '0;
    if (issue_vld && (issue_rd != '0)) begin
      set_m[issue_rd] = 1'b1;
    end
    if (wp_q.we) begin
      clr_m[wp_q.waddr] = 1'b1;
    end
  end

  // Set is applied after clear so a same-cycle reissue wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~clr_m) | set_m;
    end
  end

  assign busy = busy_q;
`else
  logic unused_issue;
  assign unused_issue = ^{issue_vld, issue_rd};
  assign busy = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized scoreboard bench for rf_wb_arbiter.
// Driver pushes model expectations; negedge monitor compares.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_vld;
  logic        alu_rdy;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wd;
  logic        lsu_vld;
  logic        lsu_rdy;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_wd;
  logic        issue_vld;
  logic [4:0]  issue_rd;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wd;
  logic [31:0] busy;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_vld   (alu_vld),
    .alu_rdy   (alu_rdy),
    .alu_rd    (alu_rd),
    .alu_wd    (alu_wd),
    .lsu_vld   (lsu_vld),
    .lsu_rdy   (lsu_rdy),
    .lsu_rd    (lsu_rd),
    .lsu_wd    (lsu_wd),
    .issue_vld (issue_vld),
    .issue_rd  (issue_rd),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wd     (rf_wd),
    .busy      (busy)
  );

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; logic a; logic l;} rdy_t;
  typedef struct {int c; logic [31:0] b;} busy_t;
  typedef struct {int c; logic [4:0] a; logic [31:0] d;} wr_t;

  rdy_t  q_rdy[$];
  busy_t q_busy[$];
  wr_t   q_wr[$];

  // Reference model state: most recent winner, pending map,
  // and the write the RF port presents this cycle.
  bit          m_last_lsu = 1'b1;
  logic [31:0] mb = '0;
  bit          m_we = 1'b0;
  logic [4:0]  m_wa = '0;
  bit          acc_a;
  bit          acc_l;

  task automatic step(
    input bit r,
    input bit va, input logic [4:0] ra, input logic [31:0] da,
    input bit vl, input logic [4:0] rl, input logic [31:0] dl,
    input bit iv, input logic [4:0] ir
  );
    bit          ea, el, wr;
    logic [4:0]  wa;
    logic [31:0] wd, nb;
    rst = r;
    alu_vld = va; alu_rd = ra; alu_wd = da;
    lsu_vld = vl; lsu_rd = rl; lsu_wd = dl;
    issue_vld = iv; issue_rd = ir;
    ea = !vl || m_last_lsu;
    el = !va || !m_last_lsu;
    q_rdy.push_back('{cyc, ea, el});
    acc_a = va && ea;
    acc_l = vl && el;
    wa = acc_a ? ra : rl;
    wd = acc_a ? da : dl;
    wr = (acc_a || acc_l) && (wa != 0) && !r;
    if (r) begin
      nb = '0;
      m_last_lsu = 1'b1;
    end else begin
      nb = mb;
      if (m_we) nb[m_wa] = 1'b0;
      if (iv && ir != 0) nb[ir] = 1'b1;
      if (acc_a) m_last_lsu = 1'b0;
      else if (acc_l) m_last_lsu = 1'b1;
    end
`ifndef RF_WB_SCOREBOARD_EN
    nb = '0;
`endif
    q_busy.push_back('{cyc + 1, nb});
    if (wr) q_wr.push_back('{cyc + 1, wa, wd});
    mb = nb;
    m_we = wr;
    m_wa = wa;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  rdy_t  mr;
  busy_t mq;
  wr_t   mw;

  always @(negedge clk) begin
    if (q_rdy.size() > 0 && q_rdy[0].c == cyc) begin
      mr = q_rdy.pop_front();
      checks++;
      if (alu_rdy !== mr.a || lsu_rdy !== mr.l) begin
        errors++;
        $display("FAIL rdy cyc %0d: got alu=%b lsu=%b exp alu=%b lsu=%b",
                 cyc, alu_rdy, lsu_rdy, mr.a, mr.l);
      end
    end
    if (q_busy.size() > 0 && q_busy[0].c == cyc) begin
      mq = q_busy.pop_front();
      checks++;
      if (busy !== mq.b) begin
        errors++;
        $display("FAIL busy cyc %0d: got %h exp %h", cyc, busy, mq.b);
      end
    end
    if (cyc >= 2) begin
      if (q_wr.size() > 0 && q_wr[0].c == cyc) begin
        mw = q_wr.pop_front();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== mw.a || rf_wd !== mw.d) begin
          errors++;
          $display("FAIL write cyc %0d: got we=%b a=%0d d=%h exp a=%0d d=%h",
                   cyc, rf_we, rf_waddr, rf_wd, mw.a, mw.d);
        end
      end else if (rf_we !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL extra_write cyc %0d: got we=%b a=%0d exp we=0",
                 cyc, rf_we, rf_waddr);
      end
    end
`ifdef RF_WB_SCOREBOARD_EN
    if (issue_vld === 1'b1 && !rst && issue_rd != 0) begin
      checks++;
      if (busy[issue_rd] &&
          !(rf_we && rf_waddr == issue_rd)) begin
        errors++;
        $display("FAIL issue_to_busy cyc %0d: rd=%0d busy=%h exp clear",
                 cyc, issue_rd, busy);
      end
    end
`endif
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h exp %h", nm, got, exp);
    end
  endtask

  bit          pa, pl, iv, r;
  logic [4:0]  ra, rl, ir;
  logic [31:0] da, dl;

  initial begin
    rst = 1'b1;
    alu_vld = 0; alu_rd = 0; alu_wd = 0;
    lsu_vld = 0; lsu_rd = 0; lsu_wd = 0;
    issue_vld = 0; issue_rd = 0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_we", {31'd0, rf_we}, 32'd0);
    chk("reset_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("reset_wd", rf_wd, 32'd0);
    chk("reset_busy", busy, 32'd0);

    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    idle();
    idle();

    step(0, 0, 0, 0, 1, 0, 32'h1234, 0, 0);
    idle();

    for (int i = 0; i < 4; i++)
      step(0, 1, 1, 32'hA1A1_0000 + i, 1, 2, 32'hB2B2_0000 + i, 0, 0);
    idle();

    step(0, 0, 0, 0, 0, 0, 0, 1, 10);
    idle(); idle(); idle();
    step(0, 0, 0, 0, 1, 10, 32'h0A0A_0A0A, 0, 0);
    idle(); idle();

    step(0, 0, 0, 0, 0, 0, 0, 1, 7);
    idle();
    step(0, 0, 0, 0, 1, 7, 32'h7777_0001, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 7);
    idle(); idle();
    step(0, 0, 0, 0, 1, 7, 32'h7777_0002, 0, 0);
    idle(); idle();

    step(0, 0, 0, 0, 0, 0, 0, 1, 3);
    step(0, 1, 4, 32'h4444_4444, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h1111_1111, 1, 2, 32'h2222_2222, 0, 0);
    idle(); idle();

    pa = 0; pl = 0;
    ra = 0; rl = 0; da = 0; dl = 0;
    for (int i = 0; i < 600; i++) begin
      if (!pa && $urandom_range(0, 99) < 60) begin
        pa = 1;
        ra = 5'($urandom_range(0, 7));
        da = $urandom;
      end
      if (!pl && $urandom_range(0, 99) < 60) begin
        pl = 1;
        rl = 5'($urandom_range(0, 7));
        dl = $urandom;
      end
      r  = ($urandom_range(0, 99) == 0);
      ir = 5'($urandom_range(1, 31));
      iv = ($urandom_range(0, 99) < 30) && !mb[ir] && !r;
      step(r, pa && !r, ra, da, pl && !r, rl, dl, iv, ir);
      if (acc_a && !r) pa = 0;
      if (acc_l && !r) pl = 0;
    end
    idle(); idle(); idle();

    chk("drain_writes", q_wr.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
